// File: rtl/pipeline_pkg.sv
// Shared definitions for the 16-bit five-stage pipeline: bypass-select codes and hazard tracking records.
// Combinational constants and types only; no latency, no flow control.
package pipeline_pkg;

  localparam int REG_ADDR_W_DEF = 3;
  // rd is held wide so the unit can be built with any register index up to 8 bits.
  localparam int REC_RD_W = 8;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_EXE = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b11;

  typedef struct packed {
    logic                valid;
    logic [REC_RD_W-1:0] rd;
    logic                regwrite;
    logic                memread;
  } hazard_rec_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter: +1 per cycle with inc high, holds at all-ones.
// Count visible one cycle after the event; never stalls its source.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Operand bypass selection and load-use stall control for the EXE-stage ALU inputs.
// Selects/stall/bubble are zero-latency combinational; shadow records never freeze, a stall only injects a bubble.
module hazard_unit
  import pipeline_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int CNT_W      = 16,
  parameter bit R0_ZERO    = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_regwrite,
  input  logic                  id_memread,
  input  logic                  flush,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel,
  output logic                  stall,
  output logic                  bubble,
  output logic [CNT_W-1:0]      stall_count,
  output logic [CNT_W-1:0]      flush_count
);

  hazard_rec_t exe_q, mem_q, wb_q, exe_d;
  logic hit_exe_a, hit_mem_a, hit_wb_a;
  logic hit_exe_b, hit_mem_b, hit_wb_b;
  logic load_use_a, load_use_b;

  function automatic logic hit(hazard_rec_t r, logic [REG_ADDR_W-1:0] s,
                               logic use_s, logic vld);
    return r.valid && r.regwrite && (r.rd == REC_RD_W'(s)) && use_s && vld &&
           !(R0_ZERO && (s == '0));
  endfunction

  // Youngest producer wins.
  function automatic logic [1:0] pick(logic he, logic hm, logic hw);
    if (he)      return FWD_EXE;
    else if (hm) return FWD_MEM;
    else if (hw) return FWD_WB;
    else         return FWD_REG;
  endfunction

  always_comb begin
    hit_exe_a  = hit(exe_q, id_rs1, id_use_rs1, id_valid);
    hit_mem_a  = hit(mem_q, id_rs1, id_use_rs1, id_valid);
    hit_wb_a   = hit(wb_q,  id_rs1, id_use_rs1, id_valid);
    hit_exe_b  = hit(exe_q, id_rs2, id_use_rs2, id_valid);
    hit_mem_b  = hit(mem_q, id_rs2, id_use_rs2, id_valid);
    hit_wb_b   = hit(wb_q,  id_rs2, id_use_rs2, id_valid);
    load_use_a = hit_exe_a && exe_q.memread;
    load_use_b = hit_exe_b && exe_q.memread;

    stall  = (load_use_a || load_use_b) && !flush;
    bubble = flush || stall;

    fwd_a_sel = FWD_REG;
    fwd_b_sel = FWD_REG;
    if (id_valid && !flush) begin
      if (!load_use_a) fwd_a_sel = pick(hit_exe_a, hit_mem_a, hit_wb_a);
      if (!load_use_b) fwd_b_sel = pick(hit_exe_b, hit_mem_b, hit_wb_b);
    end

    exe_d = '0;
    if (id_valid && !stall && !flush) begin
      exe_d.valid    = 1'b1;
      exe_d.rd       = REC_RD_W'(id_rd);
      exe_d.regwrite = id_regwrite;
      exe_d.memread  = id_memread;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      exe_q <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      exe_q <= exe_d;
      mem_q <= exe_q;
      wb_q  <= mem_q;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (stall),
    .count   (stall_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (flush),
    .count   (flush_count)
  );

endmodule
